// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, 100 MHz timing defaults,
// keyboard command bytes and the frame builder used by the host transmitter.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  // 120 us clock inhibit, 2 us start request, 15 ms ACK limit at 100 MHz.
  localparam int unsigned INHIBIT_CYCLES_100M  = 12000;
  localparam int unsigned START_CYCLES_DEFAULT = 200;
  localparam int unsigned TIMEOUT_CYCLES_100M  = 1_500_000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Bit 8 is odd parity over the data byte.
  function automatic logic [8:0] ps2_frame(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge
// detector; shared by the host transmitter and the keyboard receiver.
module ps2_sync_edge (
  input  logic clk100mhz,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic r0;
  logic r1;

  // Flops reset to 1, the idle level of an open-drain PS/2 line.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      r0 <= 1'b1;
      r1 <= 1'b1;
    end else begin
      // NOTE: non-blocking so r1 takes r0's previous value; blocking here would collapse the chain into one flop.
      r0 <= pin;
      r1 <= r0;
    end
  end

  assign level = r1;
  assign fall  = ~r0 & r1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start request,
// shifts out one command byte with odd parity and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_100M,
  parameter int unsigned START_CYCLES   = START_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_100M
) (
  input  logic       clk100mhz,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int          PCNT_W    = $clog2(PHASE_MAX + 1);

  localparam logic [PCNT_W-1:0] INHIBIT_LAST = PCNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [PCNT_W-1:0] START_LAST   = PCNT_W'(START_CYCLES - 1);
  localparam logic [20:0]       TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

  logic              clk_level;
  logic              clk_fall;
  logic              d_r0;
  logic              d_s;
  logic [2:0]        state;
  logic [8:0]        shreg;
  logic [3:0]        bitcnt;
  logic [PCNT_W-1:0] pcnt;
  logic [20:0]       tcnt;

  ps2_sync_edge u_clk_sync (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .pin       (ps2_clk),
    .level     (clk_level),
    .fall      (clk_fall)
  );

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      d_r0 <= 1'b1;
      d_s  <= 1'b1;
    end else begin
      d_r0 <= ps2_data;
      d_s  <= d_r0;
    end
  end

  // The pulse cycle still reports not-ready so ready returns one cycle later.
  assign tx_ready = (state == ST_IDLE) && !tx_done && !tx_err;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg      <= ps2_frame(tx_data);
            bitcnt     <= '0;
            pcnt       <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (pcnt == INHIBIT_LAST) begin
            pcnt        <= '0;
            ps2_data_oe <= 1'b1;
            state       <= ST_START;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        ST_START: begin
          if (pcnt == START_LAST) begin
            ps2_clk_oe <= 1'b0;
            tcnt       <= '0;
            state      <= ST_SHIFT;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        ST_SHIFT, ST_ACK, ST_RELEASE: begin
          // Timeout wins over a clock fall seen in the same cycle.
          if (tcnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 21'd1;
            if (state == ST_SHIFT) begin
              if (clk_fall) begin
                if (bitcnt == 4'd9) begin
                  ps2_data_oe <= 1'b0;
                  bitcnt      <= 4'd10;
                  state       <= ST_ACK;
                end else begin
                  ps2_data_oe <= ~shreg[0];
                  shreg       <= {1'b0, shreg[8:1]};
                  bitcnt      <= bitcnt + 4'd1;
                end
              end
            end else if (state == ST_ACK) begin
              if (clk_fall) begin
                if (!d_s) begin
                  state <= ST_RELEASE;
                end else begin
                  tx_err <= 1'b1;
                  state  <= ST_IDLE;
                end
              end
            end else begin
              if (clk_level && d_s) begin
                tx_done <= 1'b1;
                state   <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks the frame in,
// and received bits, ACK outcome, pulses and timing are checked against a model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INHIBIT = 100;
  localparam int unsigned START   = 10;
  localparam int unsigned TIMEOUT = 50000;
  // Device clock half-period, scaled down from 20 us to keep the run short.
  localparam int HALF_NS = 200;

  logic       clk100mhz = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_err;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin, ps2_data_pin;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int overlap_cnt = 0;
  int wide_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  always #5 clk100mhz = ~clk100mhz;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .START_CYCLES   (START),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk100mhz   (clk100mhz),
    .rst         (rst),
    .ps2_clk     (ps2_clk_pin),
    .ps2_data    (ps2_data_pin),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  // Pulse monitor: counts done/err pulses, overlaps and pulses wider than one cycle.
  always @(negedge clk100mhz) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
    if (tx_done && tx_err) overlap_cnt <= overlap_cnt + 1;
    if ((tx_done && prev_done) || (tx_err && prev_err)) wide_cnt <= wide_cnt + 1;
    prev_done <= tx_done;
    prev_err  <= tx_err;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device sees it: 8 data bits LSB-first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic send_byte(input logic [7:0] b, input string tag);
    @(negedge clk100mhz);
    check({tag, " ready"}, tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk100mhz);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check({tag, " accept"}, {tx_ready, busy, ps2_clk_oe}, 3'b011);
  endtask

  // Device side: wait for the request-to-send, clock in 10 bits on rising
  // edges, then ACK (or NACK) on fall 11. abort_fall>0 stops mid-frame.
  task automatic device_xfer(input bit nack, input int abort_fall,
                             output logic [9:0] bits, output int rts_wait);
    bits = '0;
    rts_wait = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && rts_wait < 1000) begin
      @(negedge clk100mhz);
      rts_wait++;
    end
    check("rts seen", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    if (!(ps2_data_oe && !ps2_clk_oe)) return;
    #(HALF_NS);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      #(HALF_NS / 2);
      if (k == abort_fall) return;
      #(HALF_NS / 2);
      dev_clk_low = 1'b0;
      bits[k-1] = ps2_data_pin;
      #(HALF_NS);
    end
    dev_data_low = !nack;
    #(HALF_NS / 2);
    dev_clk_low = 1'b1;
    #(HALF_NS);
    dev_clk_low = 1'b0;
    #(HALF_NS / 2);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(tx_ready && !busy) && n < 2000) begin
      @(negedge clk100mhz);
      n++;
    end
    check({tag, " idle"}, {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
    repeat (3) @(negedge clk100mhz);
  endtask

  task automatic xfer_ok(input logic [7:0] b, input string tag,
                         output logic [9:0] bits, output int rts_wait);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b, tag);
    device_xfer(1'b0, 0, bits, rts_wait);
    check({tag, " frame"}, bits, model_frame(b));
    wait_idle(tag);
    check({tag, " done"}, done_cnt - d0, 1);
    check({tag, " err"}, err_cnt - e0, 0);
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] rb;
    int w, n, d0, e0;

    // Reset state, held while rst is high.
    repeat (3) @(negedge clk100mhz);
    check("reset oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset ready/busy", {tx_ready, busy}, 2'b10);
    check("reset pulses", {tx_done, tx_err}, 2'b00);
    rst = 1'b0;
    repeat (2) @(negedge clk100mhz);
    check("idle after reset", {tx_ready, busy, ps2_clk_oe}, 3'b100);

    // Set-LEDs command: exact bit sequence and inhibit+start duration.
    xfer_ok(CMD_SET_LEDS, "ed", bits, w);
    check("ed bits", bits, 10'b1_1_1110_1101);
    check("ed clk_oe cycles", w, INHIBIT + START);

    xfer_ok(CMD_ENABLE, "f4", bits, w);
    check("f4 parity", bits[8], 1'b0);
    xfer_ok(8'h00, "00", bits, w);
    check("00 parity", bits[8], 1'b1);

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      xfer_ok(rb, "rand", bits, w);
    end

    // NACK: device leaves data high on fall 11.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'($urandom), "nack");
    device_xfer(1'b1, 0, bits, w);
    wait_idle("nack");
    check("nack err", err_cnt - e0, 1);
    check("nack done", done_cnt - d0, 0);

    // Device never clocks: tx_err exactly TIMEOUT cycles after clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h3C, "to");
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      @(negedge clk100mhz);
      n++;
    end
    check("to release", ps2_clk_oe, 1'b0);
    n = 0;
    while (!tx_err && n < int'(TIMEOUT) + 100) begin
      @(negedge clk100mhz);
      n++;
    end
    check("to cycles", n, TIMEOUT);
    check("to oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    wait_idle("to");
    check("to err", err_cnt - e0, 1);
    check("to done", done_cnt - d0, 0);
    xfer_ok(CMD_RESET, "ff", bits, w);

    // Reset during clock inhibit releases the clock line asynchronously.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hA5, "rsti");
    repeat (20) @(negedge clk100mhz);
    check("rsti pre", ps2_clk_oe, 1'b1);
    #2 rst = 1'b1;
    #1 check("rsti async", {ps2_clk_oe, ps2_data_oe, tx_ready, busy}, 4'b0010);
    @(negedge clk100mhz);
    rst = 1'b0;
    repeat (2) @(negedge clk100mhz);

    // Reset during bit 4 (data line pulled low) releases it asynchronously.
    rb = 8'($urandom) & 8'hF7;
    send_byte(rb, "rst4");
    device_xfer(1'b0, 4, bits, w);
    check("rst4 pre", ps2_data_oe, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst4 async", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk100mhz);
    rst = 1'b0;
    @(negedge clk100mhz);
    check("rst4 ready", {tx_ready, busy}, 2'b10);
    repeat (5) @(negedge clk100mhz);
    check("rst pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);

    // tx_valid while busy is dropped, not queued.
    d0 = done_cnt;
    rb = 8'($urandom);
    send_byte(rb, "busy");
    repeat (5) @(negedge clk100mhz);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk100mhz);
    tx_valid = 1'b0;
    device_xfer(1'b0, 0, bits, w);
    check("busy frame", bits, model_frame(rb));
    wait_idle("busy");
    n = 0;
    repeat (300) begin
      @(negedge clk100mhz);
      if (ps2_clk_oe || busy) n++;
    end
    check("busy no second", n, 0);
    check("busy done", done_cnt - d0, 1);

    check("pulse overlap", overlap_cnt, 0);
    check("pulse width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
